// File: rtl/sample_store_pkg.sv
// Shared definitions for the sample store: window state encoding and default geometry.
package sample_store_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } store_state_t;

    localparam int DEFAULT_DEPTH = 64;
    localparam int DEFAULT_DW    = 32;

endpackage

// File: rtl/sample_store_ram.sv
// DEPTH x DW storage: one synchronous write port, one asynchronous read port.
module sample_ram #(
    parameter int DEPTH = sample_store_pkg::DEFAULT_DEPTH,
    parameter int DW    = sample_store_pkg::DEFAULT_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency lookup so the regression block sees data in the cycle it asks.
    assign rdata = mem[raddr];

endmodule

// File: rtl/sample_store.sv
// Circular sample window addressed by absolute sample number, with freeze protection
// of the stored window while a fit is running.
module sample_store
    import sample_store_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          freeze,
    input  logic [31:0]   index,
    output logic [DW-1:0] value,
    output logic          hit,
    output logic [31:0]   count,
    output logic [31:0]   oldest,
    output logic [15:0]   drop_cnt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    store_state_t  state_reg, state_next;
    logic [31:0]   count_reg, count_next;
    logic [15:0]   drop_reg, drop_next;
    logic          accept;
    logic [DW-1:0] rd_data;

    // Only a write into a full window overwrites history, so only that is blocked.
    assign in_ready = !(freeze && (state_reg == ST_FULL)) && (count_reg != COUNT_MAX);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= ST_EMPTY;
            count_reg <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        drop_next  = drop_reg;
        if (accept) begin
            count_next = count_reg + 32'd1;
        end
        if (in_valid && !in_ready && (drop_reg != 16'hFFFF)) begin
            drop_next = drop_reg + 16'd1;
        end
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = (DEPTH_W == 32'd1) ? ST_FULL : ST_FILLING;
                end
            end
            ST_FILLING: begin
                if (accept && (count_reg == DEPTH_W - 32'd1)) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                state_next = ST_FULL;
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Reset wins over a simultaneous write so the discarded sample never lands.
    sample_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .Clk   (Clk),
        .we    (accept && !Rst),
        .waddr (count_reg[AW-1:0]),
        .wdata (in_data),
        .raddr (index[AW-1:0]),
        .rdata (rd_data)
    );

    assign oldest   = (count_reg < DEPTH_W) ? 32'd0 : (count_reg - DEPTH_W);
    assign hit      = (index >= oldest) && (index < count_reg);
    assign value    = hit ? rd_data : '0;
    assign count    = count_reg;
    assign drop_cnt = drop_reg;

endmodule
